// File: rtl/update_dispatcher.sv
// Update dispatcher: buffers host edge-weight updates in a FIFO and feeds the
// arbitrage container one update per run, with status and sticky error flags.
module update_dispatcher #(
  parameter int PRED_BITS      = 6,
  parameter int WEIGHT_BITS    = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [PRED_BITS-1:0]          wr_src,
  input  logic [PRED_BITS-1:0]          wr_dst,
  input  logic [WEIGHT_BITS-1:0]        wr_weight,
  output logic                          wr_ready,
  input  logic                          src_we,
  input  logic [PRED_BITS-1:0]          src_in,
  input  logic                          err_clr,
  output logic [PRED_BITS-1:0]          u_src,
  output logic [PRED_BITS-1:0]          u_dst,
  output logic [WEIGHT_BITS-1:0]        u_e,
  output logic [PRED_BITS-1:0]          src,
  output logic                          container_reset,
  input  logic                          container_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   run_count,
  output logic                          overflow_err,
  output logic                          timeout_err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * PRED_BITS + WEIGHT_BITS;
  localparam int TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_KICK = 3'd2;
  localparam logic [2:0] S_ARM  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [2:0]             state_q, state_d;
  logic [PRED_BITS-1:0]   uSrc_q, uSrc_d, uDst_q, uDst_d;
  logic [WEIGHT_BITS-1:0] uE_q, uE_d;
  logic [PRED_BITS-1:0]   src_q, src_d, srcShadow_q, srcShadow_d;
  logic                   kick_q, kick_d;
  logic [15:0]            runCount_q, runCount_d;
  logic                   ovf_q, ovf_d, to_q, to_d;
  logic [TO_W-1:0]        toCnt_q, toCnt_d;
  logic                   wrReady, push, pop;
  logic [ENTRY_W-1:0]     head;

  assign wrReady = (count_q != CNT_FULL);
  assign push    = wr_valid && wrReady;
  assign pop     = (state_q == S_LOAD);
  assign head    = mem_q[rdPtr_q];

  // Next-state logic for the FIFO bookkeeping, the run FSM and the status flags.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    uSrc_d      = uSrc_q;
    uDst_d      = uDst_q;
    uE_d        = uE_q;
    src_d       = src_q;
    srcShadow_d = src_we ? src_in : srcShadow_q;
    runCount_d  = runCount_q;
    toCnt_d     = toCnt_q;
    ovf_d       = (ovf_q && !err_clr) || (wr_valid && !wrReady);
    to_d        = to_q && !err_clr;

    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_LOAD;
      S_LOAD: begin
        {uSrc_d, uDst_d, uE_d} = head;
        src_d   = src_we ? src_in : srcShadow_q;
        state_d = S_KICK;
      end
      S_KICK: begin
        toCnt_d = '0;
        state_d = S_ARM;
      end
      // done is still left over from the previous run here, so never sample it.
      S_ARM:  state_d = S_WAIT;
      S_WAIT: begin
        if (container_done) begin
          runCount_d = runCount_q + 16'd1;
          state_d    = S_IDLE;
        end else if (toCnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    kick_d = (state_d == S_KICK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      uSrc_q      <= '0;
      uDst_q      <= '0;
      uE_q        <= '0;
      src_q       <= '0;
      srcShadow_q <= '0;
      kick_q      <= 1'b0;
      runCount_q  <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      toCnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      uSrc_q      <= uSrc_d;
      uDst_q      <= uDst_d;
      uE_q        <= uE_d;
      src_q       <= src_d;
      srcShadow_q <= srcShadow_d;
      kick_q      <= kick_d;
      runCount_q  <= runCount_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      toCnt_q     <= toCnt_d;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {wr_src, wr_dst, wr_weight};
  end

  assign wr_ready        = wrReady;
  assign u_src           = uSrc_q;
  assign u_dst           = uDst_q;
  assign u_e             = uE_q;
  assign src             = src_q;
  assign container_reset = kick_q;
  assign busy            = (state_q != S_IDLE);
  assign fifo_count      = count_q;
  assign run_count       = runCount_q;
  assign overflow_err    = ovf_q;
  assign timeout_err     = to_q;

endmodule

// File: tb/tb_update_dispatcher.sv
// Bench for update_dispatcher: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the dispatcher.
module tb_update_dispatcher;

  localparam int PB    = 6;
  localparam int WB    = 32;
  localparam int DEPTH = 16;
  localparam int TO    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [PB-1:0] wr_src = '0, wr_dst = '0;
  logic [WB-1:0] wr_weight = '0;
  logic          wr_ready;
  logic          src_we = 1'b0;
  logic [PB-1:0] src_in = '0;
  logic          err_clr = 1'b0;
  logic [PB-1:0] u_src, u_dst, src;
  logic [WB-1:0] u_e;
  logic          container_reset;
  logic          container_done = 1'b0;
  logic          busy;
  logic [4:0]    fifo_count;
  logic [15:0]   run_count;
  logic          overflow_err, timeout_err;

  always #5 clk = ~clk;

  update_dispatcher #(
    .PRED_BITS(PB), .WEIGHT_BITS(WB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_src(wr_src), .wr_dst(wr_dst),
    .wr_weight(wr_weight), .wr_ready(wr_ready), .src_we(src_we), .src_in(src_in),
    .err_clr(err_clr), .u_src(u_src), .u_dst(u_dst), .u_e(u_e), .src(src),
    .container_reset(container_reset), .container_done(container_done), .busy(busy),
    .fifo_count(fifo_count), .run_count(run_count), .overflow_err(overflow_err),
    .timeout_err(timeout_err)
  );

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending updates and a run phase counted in
  // cycles since LOAD (0 idle, 1 load, 2 kick, 3 arm, 4+ waiting).
  typedef struct packed {
    logic [PB-1:0] s;
    logic [PB-1:0] d;
    logic [WB-1:0] w;
  } upd_t;

  upd_t          mQ[$];
  int            mPhase = 0;
  logic [PB-1:0] mUsrc = '0, mUdst = '0, mSrc = '0, mShadow = '0;
  logic [WB-1:0] mUe = '0;
  int            mRun = 0;
  bit            mOvf = 0, mTo = 0;
  bit            modelValid = 0;

  task automatic modelStep();
    bit   full;
    int   sizeBefore;
    bit   toEvent;
    upd_t e;
    if (reset) begin
      mQ.delete();
      mPhase = 0; mUsrc = '0; mUdst = '0; mUe = '0; mSrc = '0; mShadow = '0;
      mRun = 0; mOvf = 0; mTo = 0; modelValid = 1;
      return;
    end
    full = (mQ.size() == DEPTH);
    sizeBefore = mQ.size();
    toEvent = 0;
    if (mPhase == 1) begin
      e = mQ.pop_front();
      mUsrc = e.s; mUdst = e.d; mUe = e.w;
      mSrc = src_we ? src_in : mShadow;
    end
    if (src_we) mShadow = src_in;
    if (wr_valid && !full) begin
      e.s = wr_src; e.d = wr_dst; e.w = wr_weight;
      mQ.push_back(e);
    end
    if (mPhase == 0) mPhase = (sizeBefore != 0) ? 1 : 0;
    else if (mPhase < 4) mPhase++;
    else if (container_done) begin mRun = (mRun + 1) % 65536; mPhase = 0; end
    else if (mPhase - 4 == TO - 1) begin toEvent = 1; mPhase = 0; end
    else mPhase++;
    mOvf = (mOvf && !err_clr) || (wr_valid && full);
    mTo  = (mTo && !err_clr) || toEvent;
  endtask

  // Compare process: advance the model on each edge, then check every output.
  always begin
    @(posedge clk);
    #1;
    modelStep();
    if (modelValid) begin
      checkOutput("busy", busy, mPhase != 0);
      checkOutput("container_reset", container_reset, mPhase == 2);
      checkOutput("fifo_count", fifo_count, mQ.size());
      checkOutput("wr_ready", wr_ready, mQ.size() != DEPTH);
      checkOutput("u_src", u_src, mUsrc);
      checkOutput("u_dst", u_dst, mUdst);
      checkOutput("u_e", u_e, mUe);
      checkOutput("src", src, mSrc);
      checkOutput("run_count", run_count, mRun);
      checkOutput("overflow_err", overflow_err, mOvf);
      checkOutput("timeout_err", timeout_err, mTo);
    end
  end

  // Container stand-in: raises done a set number of cycles after each kick.
  int latency = 20;
  bit staleMode = 0;
  bit randLat = 0;
  int doneCnt = -1;
  int kickCount = 0;

  always @(negedge clk) begin
    if (container_reset) kickCount++;
    if (staleMode) container_done = 1'b1;
    else if (container_reset) begin
      container_done = 1'b0;
      doneCnt = randLat ? int'($urandom_range(1, 8)) : latency;
    end else if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) container_done = 1'b1;
    end
  end

  task automatic applyStimulus(input bit wv, input logic [PB-1:0] s, input logic [PB-1:0] d,
                               input logic [WB-1:0] w, input bit swe, input logic [PB-1:0] sin,
                               input bit clr, input bit rst);
    @(negedge clk);
    wr_valid = wv; wr_src = s; wr_dst = d; wr_weight = w;
    src_we = swe; src_in = sin; err_clr = clr; reset = rst;
  endtask

  task automatic idle();
    applyStimulus(0, '0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic waitKick(input string name, output int k);
    k = 0;
    while (!container_reset && k < 200) begin idle(); k++; end
    checkOutput({name, "_kickSeen"}, container_reset, 1);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || fifo_count != 0) && k < budget) begin idle(); k++; end
    checkOutput({name, "_drained"}, (k < budget), 1);
  endtask

  initial begin
    int k;
    int kc;
    applyStimulus(0, '0, '0, '0, 0, '0, 0, 1);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, 1);
    idle();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_ready", wr_ready, 1);
    checkOutput("reset_fifo_count", fifo_count, 0);

    // Single write: kick appears three cycles after the write.
    latency = 20;
    applyStimulus(1, 6'd3, 6'd5, 32'h10, 0, '0, 0, 0);
    k = 0;
    do begin idle(); k++; end while (!container_reset && k < 10);
    checkOutput("single_kickLatency", k, 3);
    repeat (6) idle();
    checkOutput("single_u_src", u_src, 3);
    checkOutput("single_u_dst", u_dst, 5);
    checkOutput("single_u_e", u_e, 32'h10);
    checkOutput("single_model_u_src", mUsrc, 3);
    kc = kickCount;
    waitIdle("single", 100);
    checkOutput("single_oneKick", kickCount - kc, 0);
    checkOutput("single_run_count", run_count, 1);
    checkOutput("single_model_run", mRun, 1);

    // Stale done: exits on the first WAIT cycle, not in ARM.
    staleMode = 1;
    idle();
    applyStimulus(1, 6'd1, 6'd2, 32'hFFFF_FFF0, 0, '0, 0, 0);
    waitKick("stale", k);
    k = 0;
    while (busy && k < 20) begin idle(); k++; end
    checkOutput("stale_exitCycles", k, 3);
    checkOutput("stale_run_count", run_count, 2);
    staleMode = 0;

    // Source change: shadow loads mid-run, src follows only at the next LOAD.
    latency = 10;
    applyStimulus(0, '0, '0, '0, 1, 6'd2, 0, 0);
    applyStimulus(1, 6'd4, 6'd6, 32'h20, 0, '0, 0, 0);
    waitKick("src1", k);
    checkOutput("src_firstRun", src, 2);
    applyStimulus(0, '0, '0, '0, 1, 6'd7, 0, 0);
    repeat (3) idle();
    checkOutput("src_heldDuringRun", src, 2);
    waitIdle("src1", 100);
    applyStimulus(1, 6'd8, 6'd9, 32'h30, 0, '0, 0, 0);
    waitKick("src2", k);
    checkOutput("src_nextRun", src, 7);
    waitIdle("src2", 100);
    checkOutput("src_run_count", run_count, 4);

    // Burst: 18 back-to-back writes against a long-running first update.
    latency = 40;
    for (int i = 0; i < 18; i++)
      applyStimulus(1, PB'($urandom), PB'($urandom), $urandom, 0, '0, 0, 0);
    idle();
    checkOutput("burst_fifo_full", fifo_count, 16);
    checkOutput("burst_wr_ready", wr_ready, 0);
    checkOutput("burst_overflow", overflow_err, 1);
    latency = 3;
    waitIdle("burst", 2000);
    checkOutput("burst_run_count", run_count, 21);
    applyStimulus(0, '0, '0, '0, 0, '0, 1, 0);
    idle();
    checkOutput("burst_err_clr", overflow_err, 0);

    // Timeout: first run never completes, second one does.
    latency = -1;
    applyStimulus(1, 6'd10, 6'd11, 32'h40, 0, '0, 0, 0);
    applyStimulus(1, 6'd12, 6'd13, 32'h50, 0, '0, 0, 0);
    waitKick("timeout", k);
    k = 0;
    while (!timeout_err && k < 200) begin idle(); k++; end
    checkOutput("timeout_cycles", k, 66);
    checkOutput("timeout_run_unchanged", run_count, 21);
    latency = 5;
    waitIdle("timeout", 100);
    checkOutput("timeout_nextDispatched", run_count, 22);
    applyStimulus(0, '0, '0, '0, 0, '0, 1, 0);
    idle();
    checkOutput("timeout_err_clr", timeout_err, 0);

    // Reset mid-WAIT with three updates queued.
    latency = -1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, PB'(i + 20), PB'(i + 30), 32'(i), 0, '0, 0, 0);
    waitKick("midreset", k);
    repeat (5) idle();
    checkOutput("midreset_queued", fifo_count, 3);
    applyStimulus(0, '0, '0, '0, 0, '0, 0, 1);
    idle();
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_fifo_count", fifo_count, 0);
    checkOutput("midreset_kick", container_reset, 0);
    kc = kickCount;
    repeat (20) idle();
    checkOutput("midreset_noKick", kickCount - kc, 0);

    // Random traffic with variable container latency.
    randLat = 1;
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) < 35, PB'($urandom), PB'($urandom), $urandom,
                    $urandom_range(0, 99) < 5, PB'($urandom),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
    waitIdle("random", 2000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
